// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detection: a DEPTH-stage shift tracker of in-flight register writes drives the decode stall.
// Optional build macro HAZARD_FWD_EN: forwarding present, so non-branch consumers only stall on load-use from EX.
module hazard_scoreboard #(
  parameter int REG_AW      = 3,
  parameter int DEPTH       = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int BRANCH_ONLY = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_read_reg_1,
  input  logic              id_rr1_en,
  input  logic [REG_AW-1:0] id_read_reg_2,
  input  logic              id_rr2_en,
  input  logic [REG_AW-1:0] id_w_reg,
  input  logic              id_reg_w_en,
  input  logic              id_is_load,
  input  logic              id_branch_I,
  input  logic              id_branch_J,
  input  logic              flush,
  output logic              stall,
  output logic              hz_rr1,
  output logic              hz_rr2,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  localparam int RUN_W = $clog2(DEPTH + 2);

  logic [DEPTH-1:0]  ent_v;
  logic [DEPTH-1:0]  ent_ld;
  logic [REG_AW-1:0] ent_addr [DEPTH];
  logic [DEPTH-1:0]  elig;
  logic [RUN_W-1:0]  run_cnt;
  logic              is_branch;
  logic              qual;
  logic              push;
  logic              unused_ld;

  assign is_branch = id_branch_I | id_branch_J;
  assign qual      = (BRANCH_ONLY != 0) ? is_branch : 1'b1;
  assign unused_ld = ^ent_ld;

  // Entries a consumer is allowed to match against this cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef HAZARD_FWD_EN
      elig[i] = ent_v[i] & (is_branch | ((i == 0) & ent_ld[i]));
`else
      elig[i] = ent_v[i];
`endif
    end
  end

  always_comb begin
    hz_rr1 = 1'b0;
    hz_rr2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_rr1 = hz_rr1 | (elig[i] & (ent_addr[i] == id_read_reg_1));
      hz_rr2 = hz_rr2 | (elig[i] & (ent_addr[i] == id_read_reg_2));
    end
    hz_rr1 = hz_rr1 & id_rr1_en;
    hz_rr2 = hz_rr2 & id_rr2_en;
  end

  assign stall = id_valid & ~flush & qual & (hz_rr1 | hz_rr2);
  assign push  = id_valid & id_reg_w_en & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v         <= '0;
      ent_ld        <= '0;
      for (int i = 0; i < DEPTH; i++) ent_addr[i] <= '0;
      stall_cycles  <= '0;
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      // Older entries advance; those landing in the flush window become bubbles.
      for (int i = DEPTH - 1; i > 0; i--) begin
        ent_v[i]    <= ent_v[i-1]  & ~(flush & (i < FLUSH_DEPTH));
        ent_ld[i]   <= ent_ld[i-1] & ~(flush & (i < FLUSH_DEPTH));
        ent_addr[i] <= ent_addr[i-1];
      end
      ent_v[0]    <= push;
      ent_ld[0]   <= push & id_is_load;
      ent_addr[0] <= id_w_reg;

      if (stall) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
        if (run_cnt != RUN_W'(DEPTH + 1)) run_cnt <= run_cnt + RUN_W'(1);
        if (run_cnt == RUN_W'(DEPTH)) stall_timeout <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (BRANCH_ONLY=1 and 0) share stimulus and are checked
// every cycle against a queue-of-pending-writes reference model.
module tb_hazard_scoreboard;
  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int FD    = 1;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, rr1_en, rr2_en, w_en, is_load, br_i, br_j, flush;
  logic [AW-1:0] rr1, rr2, wreg;
  logic stall_a, hz1_a, hz2_a, to_a;
  logic stall_b, hz1_b, hz2_b, to_b;
  logic [CW-1:0] cyc_a, cyc_b;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(DEPTH), .FLUSH_DEPTH(FD), .BRANCH_ONLY(1), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read_reg_1(rr1), .id_rr1_en(rr1_en), .id_read_reg_2(rr2), .id_rr2_en(rr2_en),
    .id_w_reg(wreg), .id_reg_w_en(w_en), .id_is_load(is_load),
    .id_branch_I(br_i), .id_branch_J(br_j), .flush(flush),
    .stall(stall_a), .hz_rr1(hz1_a), .hz_rr2(hz2_a), .stall_cycles(cyc_a), .stall_timeout(to_a));

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(DEPTH), .FLUSH_DEPTH(FD), .BRANCH_ONLY(0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_read_reg_1(rr1), .id_rr1_en(rr1_en), .id_read_reg_2(rr2), .id_rr2_en(rr2_en),
    .id_w_reg(wreg), .id_reg_w_en(w_en), .id_is_load(is_load),
    .id_branch_I(br_i), .id_branch_J(br_j), .flush(flush),
    .stall(stall_b), .hz_rr1(hz1_b), .hz_rr2(hz2_b), .stall_cycles(cyc_b), .stall_timeout(to_b));

  logic [2:0]  obs_comb [2];
  logic [CW:0] obs_reg  [2];
  assign obs_comb[0] = {stall_a, hz1_a, hz2_a};
  assign obs_comb[1] = {stall_b, hz1_b, hz2_b};
  assign obs_reg[0]  = {to_a, cyc_a};
  assign obs_reg[1]  = {to_b, cyc_b};

  // Reference model: each instance (k=0 branch-only, k=1 any consumer) owns records of writes in flight.
  typedef struct {
    int inst;
    int addr;
    bit ld;
    int age;
  } rec_t;
  rec_t pend[$];
  int   m_cnt [2];
  int   m_run [2];
  bit   m_to  [2];
  bit   e_stall [2];
  bit   e_hz1   [2];
  bit   e_hz2   [2];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic bit hit(int k, int a);
    bit br = (br_i === 1'b1) || (br_j === 1'b1);
    foreach (pend[j]) begin
      if (pend[j].inst == k && pend[j].addr == a) begin
`ifdef HAZARD_FWD_EN
        if (br || (pend[j].age == 0 && pend[j].ld)) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  task automatic eval();
    for (int k = 0; k < 2; k++) begin
      bit qual = (k == 1) ? 1'b1 : (br_i | br_j);
      e_hz1[k]   = rr1_en && hit(k, int'(rr1));
      e_hz2[k]   = rr2_en && hit(k, int'(rr2));
      e_stall[k] = id_valid && !flush && qual && (e_hz1[k] || e_hz2[k]);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    eval();
  endtask

  task automatic advance();
    rec_t r;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_run[k] = 0;
        m_to[k]  = 1'b0;
      end
    end else begin
      for (int j = pend.size() - 1; j >= 0; j--) begin
        r = pend[j];
        r.age = r.age + 1;
        if (r.age >= DEPTH || (flush && r.age < FD)) pend.delete(j);
        else pend[j] = r;
      end
      for (int k = 0; k < 2; k++) begin
        if (id_valid && w_en && !e_stall[k] && !flush) begin
          r.inst = k; r.addr = int'(wreg); r.ld = is_load; r.age = 0;
          pend.push_back(r);
        end
        if (e_stall[k]) begin
          if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
          m_run[k]++;
          if (m_run[k] >= DEPTH + 1) m_to[k] = 1'b1;
        end else begin
          m_run[k] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input int r1, input bit e1, input int r2, input bit e2,
                       input int w, input bit we, input bit ld, input bit bi, input bit bj, input bit fl);
    id_valid = v;  rr1 = AW'(r1); rr1_en = e1; rr2 = AW'(r2); rr2_en = e2;
    wreg = AW'(w); w_en = we; is_load = ld; br_i = bi; br_j = bj; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) begin
      settle();
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      settle();
      n_cmp++;
      if ({stall_a, stall_b, hz1_a, hz2_a, hz1_b, hz2_b} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_comb c=%0d: got %b want 000000", c, {stall_a, stall_b, hz1_a, hz2_a, hz1_b, hz2_b});
      end
      advance();
      n_cmp++;
      if ({obs_reg[0], obs_reg[1]} !== '0) begin
        n_bad++;
        $display("FAIL reset_regs c=%0d: got a=%b b=%b want all zero", c, obs_reg[0], obs_reg[1]);
      end
    end
  endtask

  task automatic test_branch_stall();
    logic [2:0] pat_a = '0, pat_b = '0;
    logic hz_seen = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      else        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      settle();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_comb[k] !== {e_stall[k], e_hz1[k], e_hz2[k]}) begin
          n_bad++;
          $display("FAIL branch_comb[%0d] c=%0d: got %b want %b", k, c, obs_comb[k], {e_stall[k], e_hz1[k], e_hz2[k]});
        end
      end
      if (c > 0) begin
        pat_a[3-c] = stall_a;
        pat_b[3-c] = stall_b;
      end
      if (c == 1) hz_seen = hz1_a;
      advance();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_reg[k] !== {m_to[k], CW'(m_cnt[k])}) begin
          n_bad++;
          $display("FAIL branch_regs[%0d] c=%0d: got %b want %b", k, c, obs_reg[k], {m_to[k], CW'(m_cnt[k])});
        end
      end
    end
    n_cmp++;
    if ({pat_a, pat_b, hz_seen} !== 7'b110_110_1) begin
      n_bad++;
      $display("FAIL branch_pattern: got a=%b b=%b hz1=%b want a=110 b=110 hz1=1", pat_a, pat_b, hz_seen);
    end
    n_cmp++;
    if (cyc_a !== CW'(2)) begin
      n_bad++;
      $display("FAIL branch_count: got %0d want 2", cyc_a);
    end
  endtask

  task automatic test_non_branch();
    logic [2:0] pat_a = '0, pat_b = '0;
`ifdef HAZARD_FWD_EN
    logic [2:0] want_b = 3'b000;
`else
    logic [2:0] want_b = 3'b110;
`endif
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      else        drive(1, 1, 1, 3, 1, 4, 1, 0, 0, 0, 0);
      settle();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_comb[k] !== {e_stall[k], e_hz1[k], e_hz2[k]}) begin
          n_bad++;
          $display("FAIL nonbr_comb[%0d] c=%0d: got %b want %b", k, c, obs_comb[k], {e_stall[k], e_hz1[k], e_hz2[k]});
        end
      end
      if (c > 0) begin
        pat_a[3-c] = stall_a;
        pat_b[3-c] = stall_b;
      end
      advance();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_reg[k] !== {m_to[k], CW'(m_cnt[k])}) begin
          n_bad++;
          $display("FAIL nonbr_regs[%0d] c=%0d: got %b want %b", k, c, obs_reg[k], {m_to[k], CW'(m_cnt[k])});
        end
      end
    end
    n_cmp++;
    if ({pat_a, pat_b} !== {3'b000, want_b}) begin
      n_bad++;
      $display("FAIL nonbr_pattern: got a=%b b=%b want a=000 b=%b", pat_a, pat_b, want_b);
    end
  endtask

  task automatic test_flush();
    logic [2:0] pat_a = '0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        1:       drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        3:       drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        4:       drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1);
        5:       drive(1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        default: idle();
      endcase
      settle();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_comb[k] !== {e_stall[k], e_hz1[k], e_hz2[k]}) begin
          n_bad++;
          $display("FAIL flush_comb[%0d] c=%0d: got %b want %b", k, c, obs_comb[k], {e_stall[k], e_hz1[k], e_hz2[k]});
        end
      end
      if (c == 1) pat_a[2] = stall_a;
      if (c == 3) pat_a[1] = stall_a;
      if (c == 5) pat_a[0] = stall_a;
      advance();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_reg[k] !== {m_to[k], CW'(m_cnt[k])}) begin
          n_bad++;
          $display("FAIL flush_regs[%0d] c=%0d: got %b want %b", k, c, obs_reg[k], {m_to[k], CW'(m_cnt[k])});
        end
      end
    end
    n_cmp++;
    if (pat_a !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_pattern: got %b want 000", pat_a);
    end
  endtask

  task automatic test_load_use();
    logic [5:0] pat_b = '0;
`ifdef HAZARD_FWD_EN
    logic [5:0] want_b = 6'b100_000;
`else
    logic [5:0] want_b = 6'b110_110;
`endif
    do_reset();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        4:       drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        default: drive(1, 2, 1, 7, 1, 0, 0, 0, 0, 0, 0);
      endcase
      settle();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_comb[k] !== {e_stall[k], e_hz1[k], e_hz2[k]}) begin
          n_bad++;
          $display("FAIL lduse_comb[%0d] c=%0d: got %b want %b", k, c, obs_comb[k], {e_stall[k], e_hz1[k], e_hz2[k]});
        end
      end
      if (c >= 1 && c <= 3) pat_b[6-c] = stall_b;
      if (c >= 5)           pat_b[7-c] = stall_b;
      advance();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_reg[k] !== {m_to[k], CW'(m_cnt[k])}) begin
          n_bad++;
          $display("FAIL lduse_regs[%0d] c=%0d: got %b want %b", k, c, obs_reg[k], {m_to[k], CW'(m_cnt[k])});
        end
      end
    end
    n_cmp++;
    if (pat_b !== want_b) begin
      n_bad++;
      $display("FAIL lduse_pattern: got %b want %b", pat_b, want_b);
    end
  endtask

  task automatic test_reset_saturate();
    logic s1, s2;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      else        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      rst = (c == 1);
      settle();
      if (c == 1) s1 = stall_a;
      if (c == 2) s2 = stall_a;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_comb[k] !== {e_stall[k], e_hz1[k], e_hz2[k]}) begin
          n_bad++;
          $display("FAIL rstmid_comb[%0d] c=%0d: got %b want %b", k, c, obs_comb[k], {e_stall[k], e_hz1[k], e_hz2[k]});
        end
      end
      advance();
    end
    rst = 1'b0;
    n_cmp++;
    if ({s1, s2, cyc_a} !== {1'b1, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL rstmid_result: got stall=%b,%b cnt=%0d want 1,0 cnt=0", s1, s2, cyc_a);
    end
    for (int rep = 0; rep < 9; rep++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        else        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0);
        settle();
        advance();
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (obs_reg[k] !== {m_to[k], CW'(m_cnt[k])}) begin
            n_bad++;
            $display("FAIL sat_regs[%0d] rep=%0d c=%0d: got %b want %b", k, rep, c, obs_reg[k], {m_to[k], CW'(m_cnt[k])});
          end
        end
      end
    end
    n_cmp++;
    if ({to_a, cyc_a, to_b, cyc_b} !== {1'b0, {CW{1'b1}}, 1'b0, {CW{1'b1}}}) begin
      n_bad++;
      $display("FAIL sat_hold: got a=%b/%0d b=%b/%0d want 0/%0d", to_a, cyc_a, to_b, cyc_b, (1 << CW) - 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0);
      settle();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_comb[k] !== {e_stall[k], e_hz1[k], e_hz2[k]}) begin
          n_bad++;
          $display("FAIL rand_comb[%0d] c=%0d: got %b want %b", k, c, obs_comb[k], {e_stall[k], e_hz1[k], e_hz2[k]});
        end
      end
      advance();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs_reg[k] !== {m_to[k], CW'(m_cnt[k])}) begin
          n_bad++;
          $display("FAIL rand_regs[%0d] c=%0d: got %b want %b", k, c, obs_reg[k], {m_to[k], CW'(m_cnt[k])});
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_branch_stall();
    test_non_branch();
    test_flush();
    test_load_use();
    test_reset_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage stall logic.
- Replaces fixed EX/MEM write-register compares with a shift-register scoreboard of in-flight register writes, DEPTH stages deep.
- Generates a decode stall when a consumer reads a register with a pending write, inserts the bubble into its own tracker, and honours squashes from branch resolution.
- Sits beside the decode stage. Adds stall-cycle statistics and a sticky stall-timeout error flag.

Parameters:
- REG_AW, 3: register address width (2^REG_AW architectural registers; register 0 is a normal register).
- DEPTH, 2: number of in-flight stages tracked after decode (entry 0 = EX, entry DEPTH-1 = last stage before write-back commits). Must be >= 1.
- FLUSH_DEPTH, 1: number of youngest entries (0..FLUSH_DEPTH-1) cleared by flush. Must be 1..DEPTH.
- BRANCH_ONLY, 1: 1 = only branch/jump consumers (id_branch_I | id_branch_J) may stall; 0 = any valid consumer may stall.
- CNT_W, 16: width of stall_cycles.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous active-high reset.
- id_valid, input, 1: decode holds a valid instruction.
- id_read_reg_1, input, REG_AW: source register 1.
- id_rr1_en, input, 1: source 1 is actually read.
- id_read_reg_2, input, REG_AW: source register 2.
- id_rr2_en, input, 1: source 2 is actually read.
- id_w_reg, input, REG_AW: destination register.
- id_reg_w_en, input, 1: instruction writes id_w_reg.
- id_is_load, input, 1: instruction is a memory load.
- id_branch_I, input, 1: conditional branch in decode.
- id_branch_J, input, 1: jump-register in decode.
- flush, input, 1: squash younger in-flight instructions.
- stall, output, 1: hold PC and IF/ID; inject bubble into ID/EX.
- hz_rr1, output, 1: source 1 matches a pending write.
- hz_rr2, output, 1: source 2 matches a pending write.
- stall_cycles, output, CNT_W: saturating count of stalled cycles.
- stall_timeout, output, 1: sticky error flag.

Behaviour:
- Tracker state:
  - Entries e[0..DEPTH-1], each holding {v, addr, ld}.
  - Every cycle, e[i] <= e[i-1] for i >= 1.
  - e[0] <= {1, id_w_reg, id_is_load} when id_valid & id_reg_w_en & ~stall & ~flush; otherwise e[0] <= {0, x, 0} (bubble).
  - e[DEPTH-1] retires (drops off) each cycle.
- Flush:
  - After the shift, entries 0..FLUSH_DEPTH-1 are loaded with bubbles.
  - Older entries still advance normally.
  - Flush wins over a simultaneous stall.
- Match and stall logic (combinational, zero latency, from current entries only):
  - hz_rr1 = id_rr1_en & OR_i(e[i].v & e[i].addr == id_read_reg_1); hz_rr2 likewise.
  - An instruction's own id_w_reg never matches its own reads.
  - qual = BRANCH_ONLY ? (id_branch_I | id_branch_J) : 1.
  - stall = id_valid & ~flush & qual & (hz_rr1 | hz_rr2).
- Stall duration:
  - Stalling inserts a bubble, so a matching producer leaves the tracker within at most DEPTH cycles.
  - The maximum legal consecutive stall run is DEPTH cycles.
- Counters:
  - stall_cycles increments by 1 on each stalled cycle and saturates at all-ones.
  - A run counter tracks consecutive stalled cycles and clears on any non-stall cycle.
  - If a run reaches DEPTH+1, stall_timeout is set and held until rst.
- Reset (rst=1 at an edge):
  - All entries become invalid; stall_cycles=0; stall_timeout=0; run counter=0.
  - With entries invalid, stall=0, hz_rr1=0 and hz_rr2=0 during the cycle after reset.
  - Reset mid-stall drops all pending writes.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined (forwarding present):
  - Non-branch consumers match only e[0] with e[0].ld=1 (load-use), so they stall at most 1 cycle.
  - Branch/jump consumers still match all entries, because they resolve in decode.
  - hz_rr1/hz_rr2 report the qualified match used for stall.
- Undefined: all valid entries match for every consumer, as described above.
- BRANCH_ONLY=1 still suppresses non-branch stalls in both builds.

Test Plan (DEPTH=2, FLUSH_DEPTH=1, BRANCH_ONLY=1, macro undefined unless stated):
1. Reset, then idle: stall=0, stall_cycles=0, stall_timeout=0 for 5 cycles.
2. Producer writes R3, next cycle branch_I reads R3 -> stall=1 for exactly 2 cycles, hz_rr1=1, then stall=0 with branch accepted; stall_cycles=2.
3. Producer writes R3, next cycle non-branch ADD reads R3 -> stall=0. Repeat with BRANCH_ONLY=0 -> stall=1 for 2 cycles.
4. Producer writes R5, flush asserted in the next cycle together with branch_J reading R5 -> stall=0 that cycle; R5 gone from e[0]. With no intervening producer, a branch reading R5 one cycle later does not stall.
5. HAZARD_FWD_EN defined, BRANCH_ONLY=0: load to R2, then ADD reads R2 -> stall=1 for 1 cycle. Non-load write R2, then ADD reads R2 -> stall=0.
6. Assert rst mid-stall (cycle 1 of scenario 2) -> stall=0 the following cycle, stall_cycles=0. Force stall_cycles preload to all-ones and stall again -> value holds at all-ones.
